// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter that feeds the register file's single write port.
// Optional conflict statistics are built when WB_ARB_STATS_EN is defined.
module regfile_wb_arbiter #(
  parameter int WORD_WIDTH = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [IDX_WIDTH-1:0]  a_idx,
  input  logic [WORD_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [IDX_WIDTH-1:0]  b_idx,
  input  logic [WORD_WIDTH-1:0] b_data,
  output logic                  rf_write,
  output logic [IDX_WIDTH-1:0]  rf_dst_idx,
  output logic [WORD_WIDTH-1:0] rf_dst,
  output logic                  drop_reg0,
  input  logic [IDX_WIDTH-1:0]  q_idx,
`ifdef WB_ARB_STATS_EN
  input  logic                  stat_clear,
  output logic [15:0]           stat_conflicts,
`endif
  output logic                  q_pending
);

  logic                  a_full_p0, b_full_p0;
  logic [IDX_WIDTH-1:0]  a_idx_p0, b_idx_p0;
  logic [WORD_WIDTH-1:0] a_data_p0, b_data_p0;
  logic                  last_grant;
  logic                  grant_a, grant_b;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic [WORD_WIDTH-1:0] sel_data;

  // Round-robin: on a conflict the port that did not win last time goes first.
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    sel_idx  = a_idx_p0;
    sel_data = a_data_p0;
    if (a_full_p0 && (!b_full_p0 || last_grant)) begin
      grant_a = 1'b1;
    end else if (b_full_p0) begin
      grant_b  = 1'b1;
      sel_idx  = b_idx_p0;
      sel_data = b_data_p0;
    end
  end

  assign a_ready = !a_full_p0 || grant_a;
  assign b_ready = !b_full_p0 || grant_b;

  // Stage p0: holding slots
  always_ff @(posedge clock) begin
    if (reset) begin
      a_full_p0 <= 1'b0;
      b_full_p0 <= 1'b0;
    end else begin
      if (a_valid && a_ready) a_full_p0 <= 1'b1;
      else if (grant_a)       a_full_p0 <= 1'b0;
      if (b_valid && b_ready) b_full_p0 <= 1'b1;
      else if (grant_b)       b_full_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (a_valid && a_ready) begin
      a_idx_p0  <= a_idx;
      a_data_p0 <= a_data;
    end
    if (b_valid && b_ready) begin
      b_idx_p0  <= b_idx;
      b_data_p0 <= b_data;
    end
  end

  // Stage p1: registered write port; reg0 entries are consumed but never written
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_write   <= 1'b0;
      drop_reg0  <= 1'b0;
      rf_dst_idx <= '0;
      rf_dst     <= '0;
      last_grant <= 1'b1;
    end else begin
      rf_write  <= 1'b0;
      drop_reg0 <= 1'b0;
      if (grant_a || grant_b) begin
        last_grant <= grant_b;
        if (sel_idx != '0) begin
          rf_write   <= 1'b1;
          rf_dst_idx <= sel_idx;
          rf_dst     <= sel_data;
        end else begin
          drop_reg0 <= 1'b1;
        end
      end
    end
  end

  assign q_pending = (q_idx != '0) &&
                     ((a_full_p0 && (a_idx_p0 == q_idx)) ||
                      (b_full_p0 && (b_idx_p0 == q_idx)) ||
                      (rf_write && (rf_dst_idx == q_idx)));

`ifdef WB_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset || stat_clear)          stat_conflicts <= '0;
    else if (a_full_p0 && b_full_p0)  stat_conflicts <= sat_inc16(stat_conflicts);
  end
`endif

endmodule
